// File: rtl/fp_div_seq_ctrl.sv
// Sequencer for the non-restoring mantissa divider: load, ITERS add/subtract steps,
// one remainder-correction cycle, then a held result handshake.
module fp_div_seq_ctrl #(
   parameter int ITERS = 27,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic             divisor_zero,
   input  logic             abort,
   input  logic             rem_sign,
   output logic             load_en,
   output logic             step_en,
   output logic             sub_nadd,
   output logic             q_bit,
   output logic             fix_en,
   output logic [CNT_W-1:0] iter_cnt,
   output logic             busy,
   output logic             done_valid,
   input  logic             done_ready,
   output logic             div_by_zero
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      ITER = 3'd2,
      FIX  = 3'd3,
      DONE = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERS - 1);

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             op_sub_reg, op_sub_next;
   logic             rem_neg_reg, rem_neg_next;
   logic             dbz_reg, dbz_next;

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         op_sub_reg  <= 1'b1;
         rem_neg_reg <= 1'b0;
         dbz_reg     <= 1'b0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         op_sub_reg  <= op_sub_next;
         rem_neg_reg <= rem_neg_next;
         dbz_reg     <= dbz_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      op_sub_next  = op_sub_reg;
      rem_neg_next = rem_neg_reg;
      dbz_next     = dbz_reg;
      if (abort) begin
         state_next  = IDLE;
         cnt_next    = '0;
         op_sub_next = 1'b1;
         dbz_next    = 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start_valid) begin
                  if (divisor_zero) begin
                     state_next = DONE;
                     dbz_next   = 1'b1;
                  end else begin
                     state_next = LOAD;
                  end
               end
            end
            LOAD: begin
               op_sub_next = 1'b1;
               cnt_next    = '0;
               dbz_next    = 1'b0;
               state_next  = ITER;
            end
            ITER: begin
               // Next step's operation follows the sign of this step's result.
               op_sub_next  = ~rem_sign;
               rem_neg_next = rem_sign;
               if (cnt_reg == LAST_CNT) begin
                  cnt_next   = '0;
                  state_next = FIX;
               end else begin
                  cnt_next = cnt_reg + 1'b1;
               end
            end
            FIX: begin
               state_next = DONE;
            end
            DONE: begin
               if (done_ready) begin
                  state_next = IDLE;
                  dbz_next   = 1'b0;
               end
            end
            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

   assign start_ready = (state_reg == IDLE);
   assign load_en     = (state_reg == LOAD);
   assign step_en     = (state_reg == ITER);
   assign fix_en      = (state_reg == FIX) && rem_neg_reg;
   // Outside ITER the adder idles in subtract mode; FIX forces an add-back.
   assign sub_nadd    = (state_reg == ITER) ? op_sub_reg : (state_reg != FIX);
   assign q_bit       = ~rem_sign;
   assign iter_cnt    = cnt_reg;
   assign busy        = (state_reg != IDLE);
   assign done_valid  = (state_reg == DONE);
   assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_fp_div_seq_ctrl.sv
// Bench for fp_div_seq_ctrl: a reference non-restoring divider supplies rem_sign and the
// expected quotient bits, which pass through a scoreboard queue.
module tb_fp_div_seq_ctrl;
   localparam int ITERS = 27;
   localparam int CNT_W = 5;

   logic             clk = 1'b0;
   logic             n_rst = 1'b0;
   logic             start_valid = 1'b0;
   logic             start_ready;
   logic             divisor_zero = 1'b0;
   logic             abort = 1'b0;
   logic             rem_sign = 1'b0;
   logic             load_en, step_en, sub_nadd, q_bit, fix_en;
   logic [CNT_W-1:0] iter_cnt;
   logic             busy, done_valid;
   logic             done_ready = 1'b0;
   logic             div_by_zero;

   int total = 0;
   int bad = 0;
   int edges = 0;
   bit sgn [ITERS];
   int q_exp [$];

   fp_div_seq_ctrl #(.ITERS(ITERS), .CNT_W(CNT_W)) dut (
      .clk(clk), .n_rst(n_rst), .start_valid(start_valid), .start_ready(start_ready),
      .divisor_zero(divisor_zero), .abort(abort), .rem_sign(rem_sign),
      .load_en(load_en), .step_en(step_en), .sub_nadd(sub_nadd), .q_bit(q_bit),
      .fix_en(fix_en), .iter_cnt(iter_cnt), .busy(busy), .done_valid(done_valid),
      .done_ready(done_ready), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      edges++;
   endtask

   // Reference datapath: fixed point with 25 fraction bits, remainder sign per step.
   task automatic model(input longint x, input longint d);
      longint r;
      r = x - d;
      for (int k = 0; k < ITERS; k++) begin
         sgn[k] = (r < 0);
         r = sgn[k] ? (2 * r + d) : (2 * r - d);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_ready"}, int'(start_ready), 1);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_done"}, int'(done_valid), 0);
      check({tag, "_cnt"}, int'(iter_cnt), 0);
   endtask

   // mode 0: full divide; 1: abort at step 13; 2: reset at step 13
   task automatic run_div(input int mode, input bit hold_ready);
      int exp_sub;
      int qv;
      edges = 0;
      start_valid = 1'b1;
      divisor_zero = 1'b0;
      tick();
      start_valid = 1'b0;
      check("load_en", int'(load_en), 1);
      check("load_step", int'(step_en), 0);
      for (int k = 0; k < ITERS; k++) begin
         tick();
         rem_sign = sgn[k];
         q_exp.push_back(sgn[k] ? 0 : 1);
         #1;
         exp_sub = (k == 0) ? 1 : (sgn[k-1] ? 0 : 1);
         check("step_en", int'(step_en), 1);
         check("iter_cnt", int'(iter_cnt), k);
         check("sub_nadd", int'(sub_nadd), exp_sub);
         check("one_hot", int'(load_en) + int'(fix_en), 0);
         if (q_exp.size() == 0) begin
            check("sb_empty", 0, 1);
         end else begin
            qv = q_exp.pop_front();
            check("q_bit", int'(q_bit), qv);
         end
         if (k == 13 && mode != 0) begin
            if (mode == 1) abort = 1'b1;
            else n_rst = 1'b0;
            tick();
            abort = 1'b0;
            n_rst = 1'b1;
            check_idle(mode == 1 ? "abort" : "rst");
            $display("divide interrupted at step 13 mode=%0d", mode);
            return;
         end
      end
      tick();
      check("fix_step", int'(step_en), 0);
      check("fix_en", int'(fix_en), sgn[ITERS-1] ? 1 : 0);
      check("fix_sub", int'(sub_nadd), 0);
      tick();
      check("done_valid", int'(done_valid), 1);
      check("latency", edges, ITERS + 3);
      check("done_dbz", int'(div_by_zero), 0);
      check("done_fix", int'(fix_en), 0);
      if (hold_ready) begin
         start_valid = 1'b1;
         for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_done", int'(done_valid), 1);
            check("hold_ready", int'(start_ready), 0);
            check("hold_load", int'(load_en), 0);
         end
      end
      done_ready = 1'b1;
      tick();
      done_ready = 1'b0;
      check("exit_idle", int'(start_ready), 1);
      check("exit_done", int'(done_valid), 0);
      if (hold_ready) begin
         tick();
         start_valid = 1'b0;
         check("b2b_load", int'(load_en), 1);
         abort = 1'b1;
         tick();
         abort = 1'b0;
         check_idle("b2b_abort");
      end
      $display("divide complete last_sign=%0d hold=%0d", sgn[ITERS-1], hold_ready);
   endtask

   initial begin
      n_rst = 1'b0;
      tick();
      tick();
      n_rst = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         check_idle("reset");
         check("reset_sub", int'(sub_nadd), 1);
         check("reset_en", int'(load_en) + int'(step_en) + int'(fix_en), 0);
      end
      $display("reset idle checked");

      // 1.5 / 1.25 with 25 fraction bits
      model(64'd50331648, 64'd41943040);
      run_div(0, 1'b0);

      // divide by zero
      edges = 0;
      start_valid = 1'b1;
      divisor_zero = 1'b1;
      tick();
      start_valid = 1'b0;
      divisor_zero = 1'b0;
      check("dz_done", int'(done_valid), 1);
      check("dz_flag", int'(div_by_zero), 1);
      check("dz_latency", edges, 1);
      check("dz_load", int'(load_en) + int'(step_en), 0);
      done_ready = 1'b1;
      tick();
      done_ready = 1'b0;
      check_idle("dz_exit");
      $display("divide by zero checked");

      // final remainder forced negative / non-negative
      sgn[ITERS-1] = 1'b1;
      run_div(0, 1'b0);
      sgn[ITERS-1] = 1'b0;
      run_div(0, 1'b1);

      // arbitrary sign pattern
      for (int k = 0; k < ITERS; k++) sgn[k] = 1'($urandom_range(0, 1));
      run_div(0, 1'b0);

      // interruptions, each followed by a clean divide
      model(64'd50331648, 64'd41943040);
      run_div(1, 1'b0);
      run_div(0, 1'b0);
      run_div(2, 1'b0);
      run_div(0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
